// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks the PC through instruction memory and buffers
// fetched {pc, instruction} pairs in a 2-entry FIFO toward decode.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC  = 16'd0,
    parameter logic [15:0] LAST_ADDR = 16'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc,
    input  logic [31:0] instruction,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [15:0] out_pc,
    output logic        done
);

    typedef enum logic {RUN, DONE} state_t;

    localparam state_t RESET_STATE = (RESET_PC > LAST_ADDR) ? DONE : RUN;

    state_t      state, state_next;
    logic [1:0]  count, count_next;
    logic [15:0] pc_next;
    logic [15:0] pc0, pc1, pc0_next, pc1_next;
    logic [31:0] ins0, ins1, ins0_next, ins1_next;
    logic        done_next;
    logic        push, pop;
    logic [16:0] pc_inc;

    assign out_valid = (count != 2'd0);
    assign out_pc    = out_valid ? pc0 : 16'd0;
    assign out_instr = out_valid ? ins0 : 32'd0;

    always_comb begin
        state_next = state;
        count_next = count;
        pc_next    = pc;
        pc0_next   = pc0;
        pc1_next   = pc1;
        ins0_next  = ins0;
        ins1_next  = ins1;
        push       = 1'b0;
        pop        = 1'b0;
        pc_inc     = {1'b0, pc} + 17'd1;

        if (redirect) begin
            count_next = 2'd0;
            pc_next    = redirect_pc;
            state_next = (redirect_pc <= LAST_ADDR) ? RUN : DONE;
        end else begin
            pop  = (count != 2'd0) && out_ready;
            push = (state == RUN) && ((count != 2'd2) || pop);

            // The 17-bit increment lets the top of memory stop cleanly instead of wrapping to 0.
            if (push) begin
                pc_next = pc_inc[16] ? pc : pc_inc[15:0];
                if (pc == LAST_ADDR)
                    state_next = DONE;
            end

            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        pc0_next  = pc;
                        ins0_next = instruction;
                    end else begin
                        pc1_next  = pc;
                        ins1_next = instruction;
                    end
                    count_next = count + 2'd1;
                end
                2'b01: begin
                    pc0_next   = pc1;
                    ins0_next  = ins1;
                    count_next = count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        pc0_next  = pc;
                        ins0_next = instruction;
                    end else begin
                        pc0_next  = pc1;
                        ins0_next = ins1;
                        pc1_next  = pc;
                        ins1_next = instruction;
                    end
                end
                default: ;
            endcase
        end

        done_next = (state_next == DONE) && (count_next == 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
            count <= 2'd0;
            pc    <= RESET_PC;
            pc0   <= 16'd0;
            pc1   <= 16'd0;
            ins0  <= 32'd0;
            ins1  <= 32'd0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            pc    <= pc_next;
            pc0   <= pc0_next;
            pc1   <= pc1_next;
            ins0  <= ins0_next;
            ins1  <= ins1_next;
            done  <= done_next;
        end
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'd0: first fetch address after reset.
REQ-002 SHALL have parameter LAST_ADDR, default 16'd16: highest valid instruction-memory word address.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous reset, active-low.
REQ-005 SHALL have port pc  output  16: word address driven to the instruction memory, equal to the internal PC register.
REQ-006 SHALL have port instruction  input  32: memory read data, combinationally valid for pc in the same cycle.
REQ-007 SHALL have port redirect  input  1: branch/jump taken; flushes the block and reloads the PC.
REQ-008 SHALL have port redirect_pc  input  16: target address, sampled when redirect=1.
REQ-009 SHALL have port out_valid  output  1: head of the fetch buffer is valid toward decode.
REQ-010 SHALL have port out_ready  input  1: decode accepts the head entry this cycle.
REQ-011 SHALL have port out_instr  output  32: instruction word at the buffer head.
REQ-012 SHALL have port out_pc  output  16: address the head instruction was fetched from.
REQ-013 SHALL have port done  output  1: program exhausted and buffer drained.

Function
REQ-014 SHALL hold a 2-entry FIFO of {pc, instruction} pairs with a 2-bit occupancy count (0..2).
REQ-015 SHALL implement states RUN (fetching) and DONE (PC beyond LAST_ADDR, no fetching).
REQ-016 SHALL pop when out_valid && out_ready; out_valid = (count != 0); out_instr/out_pc reflect the head entry, or 0 when the FIFO is empty.
REQ-017 SHALL push {pc, instruction} and set PC <= PC+1 when state=RUN, redirect=0, and (count<2 or a pop occurs the same cycle).
REQ-018 SHALL allow simultaneous push and pop at count 1 or 2; count is unchanged and order is preserved.
REQ-019 SHALL, when no push is possible because the FIFO is full with no pop, hold PC and FIFO contents unchanged (back-pressure stall).
REQ-020 SHALL, when a push is made from PC=LAST_ADDR, enter DONE at the next edge; PC increment SHALL use 17-bit arithmetic, so LAST_ADDR=16'hFFFF enters DONE and never wraps to 0.
REQ-021 SHALL in DONE neither push nor change PC; pops continue until count=0.
REQ-022 SHALL drive done=1 only when state=DONE and count=0; registered output.
REQ-023 SHALL give redirect priority over push and pop: clear count to 0, discard both entries, load PC <= redirect_pc, and make no push in that cycle; decode sees out_valid=0 on the next cycle (one-cycle bubble).
REQ-024 SHALL, on redirect, enter RUN if redirect_pc <= LAST_ADDR, else DONE; a redirect in DONE therefore restarts fetching.
REQ-025 SHALL give a latency of one cycle from a push to that entry appearing at the head when the FIFO was empty.
REQ-026 SHALL ignore redirect_pc when redirect=0.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronously), force PC=RESET_PC, count=0, state=RUN (or DONE if RESET_PC>LAST_ADDR), out_valid=0, out_instr=0, out_pc=0, done=0.
REQ-028 SHALL discard all buffered entries when reset is asserted mid-operation; the first push after rst_n rises occurs at the first rising clk edge, fetching RESET_PC.

Verification
REQ-029 Reset release, out_ready=1 constant, memory word[a]=a+32'hA000 -> out_pc sequence 0,1,2,... one per cycle from the 2nd cycle, out_instr=A000+out_pc; after out_pc=16 drains, done=1, pc holds 17.
REQ-030 out_ready=0 for 5 cycles from reset -> count reaches 2, pc holds 2, out_pc stays 0; out_ready=1 -> heads 0,1,2 delivered in order with no loss or duplicate.
REQ-031 redirect=1, redirect_pc=9 while count=2 -> next cycle out_valid=0, pc=9; the following cycle out_pc=9; old entries never appear.
REQ-032 Reach done=1, then redirect=1, redirect_pc=3 -> done=0 the next cycle, fetching resumes at 3; redirect_pc=20 instead -> DONE held, done=1 after one cycle.
REQ-033 rst_n pulsed low between edges with count=2, pc=7 -> outputs zero immediately (before the next edge); after release the fetch restarts at RESET_PC.
REQ-034 LAST_ADDR=16'hFFFF, redirect_pc=16'hFFFF -> one push of address FFFF, then DONE; pc never returns to 0.
